// File: rtl/tof_frame_packer.sv
// tof_frame_packer: groups per-trigger TOF results into frames (header plus up to 4 data
// words). Frames are buffered in a first-word-fall-through FIFO and drained over a
// valid/ready stream. Optional macro TOF_FRAME_SEQ_EN adds a 10-bit frame sequence number
// to header[9:0]. Without it, that field is zero and no counter is built.
//
// Stream handshake: a word transfers on a clock edge where m_valid && m_ready are both high.
// m_valid depends only on FIFO occupancy, never on m_ready. While m_valid is high and
// m_ready is low, m_data and m_last hold steady.
module tof_frame_packer #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tri_en,
  input  logic [1:0]  tof_num_cnt,
  input  logic        tof_valid,
  input  logic [14:0] tof_data,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_done,
  output logic [7:0]  drop_cnt,
  output logic        err_retrig
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_WRITE} state_t;

  // Frame-assembly state (state_q is the observable FSM state)
  state_t      state_q;
  logic [2:0]  exp_q;
  logic [2:0]  hit_cnt_q;
  logic [2:0]  new_cnt;
  logic [TW-1:0] timer_q;
  logic        to_q;
  logic        oor_q;
  logic [14:0] hit_buf_q [4];
  logic [1:0]  wr_idx_q;
  logic        wr_last;
  logic [9:0]  seq_field;

  // FIFO state
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] free;
  logic          empty;
  logic          pop;
  logic          push;
  logic [16:0]   push_word;
  logic          space_ok;

`ifdef TOF_FRAME_SEQ_EN
  logic [9:0] seq_q;
  assign seq_field = seq_q;

  // Sequence number advances on every closed frame, written or dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= '0;
    else if (state_q == S_CHECK) seq_q <= seq_q + 10'd1;
  end
`else
  assign seq_field = '0;
`endif

  assign new_cnt  = hit_cnt_q + {2'b00, tof_valid};
  assign wr_last  = ({1'b0, wr_idx_q} + 3'd1) == hit_cnt_q;
  assign empty    = (count_q == '0);
  assign m_valid  = !empty;
  assign pop      = m_valid && m_ready;
  assign free     = CW'(DEPTH) - count_q;
  assign space_ok = free >= (CW'(hit_cnt_q) + CW'(1));
  assign m_data   = empty ? 16'h0000 : mem[rd_ptr_q][15:0];
  assign m_last   = empty ? 1'b0 : mem[rd_ptr_q][16];

  // Header is pushed in CHECK so it reaches the stream two cycles after the closing hit
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      S_CHECK: begin
        if (space_ok) begin
          push      = 1'b1;
          push_word = {(hit_cnt_q == 3'd0), 1'b1, hit_cnt_q, to_q, oor_q, seq_field};
        end
      end
      S_WRITE: begin
        push      = 1'b1;
        push_word = {wr_last, 1'b0, hit_buf_q[wr_idx_q]};
      end
      default: begin
        push      = 1'b0;
        push_word = '0;
      end
    endcase
  end

  // FIFO storage has no reset; pointers and count decide what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Frame FSM: collect hits, check FIFO space, write header and data words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      exp_q      <= 3'd1;
      hit_cnt_q  <= '0;
      timer_q    <= '0;
      to_q       <= 1'b0;
      oor_q      <= 1'b0;
      wr_idx_q   <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      err_retrig <= 1'b0;
      for (int i = 0; i < 4; i++) hit_buf_q[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tri_en && (state_q != S_IDLE)) err_retrig <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tri_en) begin
            exp_q     <= {1'b0, tof_num_cnt} + 3'd1;
            hit_cnt_q <= '0;
            timer_q   <= '0;
            to_q      <= 1'b0;
            oor_q     <= 1'b0;
            wr_idx_q  <= '0;
            state_q   <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (tof_valid) begin
            hit_buf_q[hit_cnt_q[1:0]] <= tof_data;
            if (tof_data == 15'h7FFF) oor_q <= 1'b1;
          end
          hit_cnt_q <= new_cnt;
          timer_q   <= timer_q + TW'(1);
          if (new_cnt == exp_q) begin
            to_q    <= 1'b0;
            state_q <= S_CHECK;
          end else if (timer_q == TLAST) begin
            to_q    <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (space_ok) begin
            wr_idx_q <= '0;
            if (hit_cnt_q == 3'd0) begin
              frame_done <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_WRITE;
            end
          end else begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          wr_idx_q <= wr_idx_q + 2'd1;
          if (wr_last) begin
            frame_done <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tof_frame_packer.sv
// tb_tof_frame_packer: directed test of tof_frame_packer with a stream scoreboard.
module tb_tof_frame_packer;

  logic        clk;
  logic        rst_n;
  logic        tri_en;
  logic [1:0]  tof_num_cnt;
  logic        tof_valid;
  logic [14:0] tof_data;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        frame_done;
  logic [7:0]  drop_cnt;
  logic        err_retrig;

  int n_checks = 0;
  int n_errors = 0;
  int nframes  = 0;
  logic [16:0] exp_q[$];

  tof_frame_packer dut (
    .clk(clk), .rst_n(rst_n), .tri_en(tri_en), .tof_num_cnt(tof_num_cnt),
    .tof_valid(tof_valid), .tof_data(tof_data), .m_data(m_data), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done),
    .drop_cnt(drop_cnt), .err_retrig(err_retrig)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig(input logic [1:0] num);
    tri_en = 1'b1;
    tof_num_cnt = num;
    tick();
    tri_en = 1'b0;
  endtask

  task automatic hit(input logic [14:0] d);
    tof_valid = 1'b1;
    tof_data = d;
    tick();
    tof_valid = 1'b0;
  endtask

  function automatic logic [16:0] hdr(input int n, input logic to, input logic oor);
    logic [9:0] sq;
`ifdef TOF_FRAME_SEQ_EN
    sq = 10'(nframes);
`else
    sq = 10'd0;
`endif
    return {(n == 0), 1'b1, 3'(n), to, oor, sq};
  endfunction

  // Queue the expected words of one frame and advance the bench frame counter
  task automatic push_frame(input int n, input logic to,
                            input logic [14:0] h0, input logic [14:0] h1,
                            input logic [14:0] h2, input logic [14:0] h3);
    logic [14:0] h [4];
    logic oor;
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
    oor = 1'b0;
    for (int i = 0; i < n; i++) if (h[i] == 15'h7FFF) oor = 1'b1;
    exp_q.push_back(hdr(n, to, oor));
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 1'b0, h[i]});
    nframes++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  // Scoreboard: every accepted stream word must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", {15'd0, m_last, m_data}, 32'h0);
      else check("stream_word", {15'd0, m_last, m_data}, {15'd0, exp_q.pop_front()});
    end
  end

  initial begin
    rst_n = 1'b0; tri_en = 1'b0; tof_num_cnt = 2'd0; tof_valid = 1'b0;
    tof_data = '0; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_err_retrig", err_retrig, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: two hits, header two cycles after the closing hit
    push_frame(2, 1'b0, 15'd100, 15'd200, 15'd0, 15'd0);
    pulse_trig(2'd1);
    hit(15'd100);
    hit(15'd200);
    tick();
    check("t1_latency_valid", m_valid, 1'b1);
    check("t1_latency_hdr", m_data, 16'hA000);
    wait_done("t1_done", 10);
    wait_drain("t1_drain", 20);

    // 2: one out-of-range hit of four expected, frame closed by timeout
    push_frame(1, 1'b1, 15'h7FFF, 15'd0, 15'd0, 15'd0);
    pulse_trig(2'd3);
    hit(15'h7FFF);
    wait_done("t2_done", 1100);
    wait_drain("t2_drain", 20);

    // 5: completing hit lands on the final timeout cycle
    push_frame(2, 1'b0, 15'h0123, 15'h4567, 15'd0, 15'd0);
    pulse_trig(2'd1);
    hit(15'h0123);
    repeat (1022) tick();
    hit(15'h4567);
    wait_done("t5_done", 10);
    wait_drain("t5_drain", 20);

    // 4: retrigger during COLLECT is flagged and ignored
    push_frame(2, 1'b0, 15'h0AAA, 15'h0555, 15'd0, 15'd0);
    pulse_trig(2'd1);
    hit(15'h0AAA);
    pulse_trig(2'd2);
    hit(15'h0555);
    check("t4_err_retrig", err_retrig, 1'b1);
    wait_done("t4_done", 10);
    repeat (20) tick();
    check("t4_no_second_valid", m_valid, 1'b0);
    check("t4_queue_empty", exp_q.size(), 0);

    // 3: stalled stream, three 4-hit frames fit, fourth is dropped
    m_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (f < 3) push_frame(4, 1'b0, 15'h0011, 15'h0022, 15'h0033, 15'h7FFF);
      else nframes++;
      pulse_trig(2'd3);
      hit(15'h0011); hit(15'h0022); hit(15'h0033); hit(15'h7FFF);
      if (f < 3) wait_done("t3_done", 10);
      else repeat (4) tick();
    end
    check("t3_drop_cnt", drop_cnt, 8'd1);
    check("t3_full_valid", m_valid, 1'b1);
    check("t3_head_hdr", m_data, 16'hC400 | 16'(hdr(4, 1'b0, 1'b1)));
    m_ready = 1'b1;
    wait_drain("t3_drain", 100);

    // 6: reset in the middle of WRITE discards everything
    m_ready = 1'b0;
    pulse_trig(2'd3);
    hit(15'd1); hit(15'd2); hit(15'd3); hit(15'd4);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_m_valid", m_valid, 1'b0);
    check("t6_drop_cnt", drop_cnt, 8'd0);
    check("t6_err_retrig", err_retrig, 1'b0);
    exp_q.delete();
    nframes = 0;
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    push_frame(1, 1'b0, 15'd5, 15'd0, 15'd0, 15'd0);
    pulse_trig(2'd0);
    hit(15'd5);
    wait_done("t6_done", 10);
    wait_drain("t6_drain", 20);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
